// File: rtl/fft_out_reorder.sv
`default_nettype none
// ============================================================================
// Module  : fft_out_reorder
// Brief   : Reorders 4-lane bit-reversed FFT output frames into natural bin
//           order using ping-pong frame banks; 4 bins per output beat.
// Revision: 1.0 - initial release
// ============================================================================
module fft_out_reorder #(
    parameter int NBITS = 10,
    parameter int N     = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [2*NBITS-1:0] in0_up,
    input  logic [2*NBITS-1:0] in0_down,
    input  logic [2*NBITS-1:0] in1_up,
    input  logic [2*NBITS-1:0] in1_down,
    output logic [2*NBITS-1:0] out0,
    output logic [2*NBITS-1:0] out1,
    output logic [2*NBITS-1:0] out2,
    output logic [2*NBITS-1:0] out3,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eof,
    output logic               abort
);
    localparam int W     = 2 * NBITS;
    localparam int LOG2N = $clog2(N);
    localparam int BEATS = N / 4;
    localparam int CW    = LOG2N - 2;
    localparam logic [CW-1:0] C_LAST = CW'(BEATS - 1);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DRAIN = 1'b1} rstate_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    logic [W-1:0] mem_q [2][N];
    logic [W-1:0] lane  [4];

    assign lane[0] = in0_up;
    assign lane[1] = in0_down;
    assign lane[2] = in1_up;
    assign lane[3] = in1_down;

    wstate_t       wstate_q, wstate_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          done_q, done_d;
    logic          done_bank_q, done_bank_d;
    logic          abort_q, abort_d;
    logic          wr_en;
    logic [CW-1:0] wr_beat;

    // An sof beat always restarts the frame in the current bank, aborting any fill.
    always_comb begin
        wstate_d    = wstate_q;
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        done_d      = 1'b0;
        done_bank_d = done_bank_q;
        abort_d     = 1'b0;
        wr_en       = 1'b0;
        wr_beat     = wr_cnt_q;
        if (in_valid && in_sof) begin
            abort_d  = (wstate_q == W_FILL);
            wr_en    = 1'b1;
            wr_beat  = '0;
            wr_cnt_d = CW'(1);
            wstate_d = W_FILL;
        end else if (in_valid && (wstate_q == W_FILL)) begin
            wr_en = 1'b1;
            if (wr_cnt_q == C_LAST) begin
                done_d      = 1'b1;
                done_bank_d = wr_bank_q;
                wr_bank_d   = ~wr_bank_q;
                wr_cnt_d    = '0;
                wstate_d    = W_IDLE;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                mem_q[wr_bank_q][bitrev({wr_beat, 2'(l)})] <= lane[l];
            end
        end
    end

    rstate_t       rstate_q, rstate_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eof_q, out_eof_d;
    logic [W-1:0]  out_q [4];
    logic [W-1:0]  out_d [4];
    logic          emit;
    logic [CW-1:0] emit_beat;
    logic          emit_bank;

    // Beat 0 of a completed frame is emitted straight from R_IDLE, so a frame
    // completing as the previous drain ends keeps out_valid continuous.
    always_comb begin
        rstate_d  = rstate_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        emit      = 1'b0;
        emit_beat = rd_cnt_q;
        emit_bank = rd_bank_q;
        case (rstate_q)
            R_IDLE: begin
                if (done_q) begin
                    emit      = 1'b1;
                    emit_beat = '0;
                    emit_bank = done_bank_q;
                    rd_bank_d = done_bank_q;
                    rd_cnt_d  = CW'(1);
                    rstate_d  = R_DRAIN;
                end
            end
            R_DRAIN: begin
                emit = 1'b1;
                if (rd_cnt_q == C_LAST) begin
                    rd_cnt_d = '0;
                    rstate_d = R_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        out_valid_d = emit;
        out_sof_d   = emit && (emit_beat == '0);
        out_eof_d   = emit && (emit_beat == C_LAST);
        for (int j = 0; j < 4; j++) begin
            out_d[j] = emit ? mem_q[emit_bank][{emit_beat, 2'(j)}] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate_q    <= W_IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            done_q      <= 1'b0;
            done_bank_q <= 1'b0;
            abort_q     <= 1'b0;
            rstate_q    <= R_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int j = 0; j < 4; j++) out_q[j] <= '0;
        end else begin
            wstate_q    <= wstate_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            done_q      <= done_d;
            done_bank_q <= done_bank_d;
            abort_q     <= abort_d;
            rstate_q    <= rstate_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            for (int j = 0; j < 4; j++) out_q[j] <= out_d[j];
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign abort     = abort_q;

endmodule
`default_nettype wire
